// File: rtl/mem_boot_arbiter.sv
// Two-master arbiter in front of one slave bus. The CPU master is held off until the
// firmware loader signals boot_done, and a slave that stalls too long is aborted with ERR_DATA.
module mem_boot_arbiter #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        boot_done,
  output logic [1:0]  grant,
  output logic [7:0]  err_count
);

  // state | meaning
  // IDLE  | no owner, arbitrating eligible requests
  // BUSY  | granted master driving the slave bus
  // ABORT | one-cycle error response to the granted master
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  // Last wait-count value seen in BUSY before the abort; the abort cycle itself is the TIMEOUT-th.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 2);

  logic [1:0]  state;
  logic [1:0]  grant_q;
  logic        boot_q;
  logic        last_m1;
  logic [15:0] wait_cnt;
  logic [7:0]  err_q;

  logic elig0, elig1, pick_m1, gnt_m1, sel_valid, busy, abort;

  always_comb begin
    elig0     = m0_valid;
    elig1     = m1_valid & boot_q;
    pick_m1   = elig1 & (~elig0 | ~last_m1);
    gnt_m1    = grant_q[1];
    sel_valid = gnt_m1 ? m1_valid : m0_valid;
    busy      = (state == ST_BUSY);
    abort     = (state == ST_ABORT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      grant_q  <= 2'b00;
      boot_q   <= 1'b0;
      last_m1  <= 1'b1;
      wait_cnt <= 16'd0;
      err_q    <= 8'd0;
    end else begin
      boot_q <= boot_q | boot_done;
      case (state)
        ST_IDLE: begin
          if (elig0 || elig1) begin
            state    <= ST_BUSY;
            grant_q  <= pick_m1 ? 2'b10 : 2'b01;
            wait_cnt <= 16'd0;
          end
        end
        ST_BUSY: begin
          if (!sel_valid) begin
            state   <= ST_IDLE;
            grant_q <= 2'b00;
          end else if (s_ready) begin
            state   <= ST_IDLE;
            grant_q <= 2'b00;
            last_m1 <= gnt_m1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            if (wait_cnt == WAIT_LAST) state <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          state   <= ST_IDLE;
          grant_q <= 2'b00;
          last_m1 <= gnt_m1;
          if (err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    s_valid  = busy & sel_valid;
    s_addr   = 32'd0;
    s_wdata  = 32'd0;
    s_wstrb  = 4'd0;
    if (busy) begin
      s_addr  = gnt_m1 ? m1_addr  : m0_addr;
      s_wdata = gnt_m1 ? m1_wdata : m0_wdata;
      s_wstrb = gnt_m1 ? m1_wstrb : m0_wstrb;
    end
    m0_ready = (busy & grant_q[0] & m0_valid & s_ready) | (abort & grant_q[0]);
    m1_ready = (busy & grant_q[1] & m1_valid & s_ready) | (abort & grant_q[1]);
    m0_rdata = 32'd0;
    m1_rdata = 32'd0;
    if (busy && grant_q[0])  m0_rdata = s_rdata;
    if (busy && grant_q[1])  m1_rdata = s_rdata;
    if (abort && grant_q[0]) m0_rdata = ERR_DATA;
    if (abort && grant_q[1]) m1_rdata = ERR_DATA;
  end

  assign grant     = grant_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_mem_boot_arbiter.sv
// Bench for mem_boot_arbiter: directed scenarios plus randomized transfers against
// a transaction-level model (round-robin owner, response cycle, data, error count).
module tb_mem_boot_arbiter;
  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

  logic        clk, resetn;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic        s_valid, s_ready, boot_done;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_last_m1;
  int m_err;

  mem_boot_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .boot_done(boot_done), .grant(grant), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] sat_err(input int n);
    return (n > 255) ? 8'd255 : n[7:0];
  endfunction

  task automatic clear_inputs();
    m0_valid = 0; m1_valid = 0; s_ready = 0; boot_done = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    m0_wstrb = 0; m1_wstrb = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    m_last_m1 = 1;
    m_err = 0;
  endtask

  // Drives one request round from IDLE and reports what the DUT did; ends in IDLE at edge+1.
  task automatic run_xfer(input bit v0, input bit v1, input logic [31:0] a0, input logic [31:0] a1,
                          input int lat, input logic [31:0] data,
                          output logic [1:0] g, output logic [31:0] saddr, output int done_cyc,
                          output bit got_m1, output logic [31:0] rd, output bit stray);
    m0_valid = v0; m1_valid = v1; m0_addr = a0; m1_addr = a1; s_ready = 0;
    m0_wdata = a0 ^ 32'h5A5A_5A5A; m1_wdata = a1 ^ 32'hA5A5_A5A5;
    @(posedge clk); #1;
    g = grant; saddr = s_addr; done_cyc = 0; got_m1 = 0; rd = '0; stray = 0;
    for (int c = 1; c <= 12; c++) begin
      s_ready = (c == lat); s_rdata = data;
      #1;
      if ((g[0] && m1_ready) || (g[1] && m0_ready)) stray = 1;
      if (m0_ready || m1_ready) begin
        done_cyc = c; got_m1 = m1_ready; rd = m1_ready ? m1_rdata : m0_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    if (done_cyc != 0) begin
      @(posedge clk); #1;
    end
    m0_valid = 0; m1_valid = 0; s_ready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant !== 2'b00 || s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: grant=%b s_valid=%b m0_ready=%b m1_ready=%b err=%0d, want all zero",
               grant, s_valid, m0_ready, m1_ready, err_count);
    end
  endtask

  task automatic test_boot_gating();
    logic [1:0] g; logic [31:0] sa, rd; int dc; bit gm1, stray;
    run_xfer(1, 1, 32'h100, 32'h200, 2, 32'hCAFE_0001, g, sa, dc, gm1, rd, stray);
    checks++;
    if (g !== 2'b01 || dc != 2 || gm1 || rd !== 32'hCAFE_0001 || stray) begin
      errors++;
      $display("FAIL boot_gate_m0: grant=%b cyc=%0d m1=%0d rdata=%h stray=%0d, want 01 2 0 cafe0001 0",
               g, dc, gm1, rd, stray);
    end
    m_last_m1 = 0;
    m1_valid = 1; m1_addr = 32'h300; s_ready = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      checks++;
      if (m1_ready !== 1'b0 || grant !== 2'b00) begin
        errors++;
        $display("FAIL boot_gate_m1 cycle %0d: m1_ready=%b grant=%b, want 0 00", i, m1_ready, grant);
      end
    end
    m1_valid = 0; s_ready = 0;
  endtask

  task automatic test_round_robin();
    bit exp_m1;
    do_reset();
    boot_done = 1;
    @(posedge clk); #1;
    boot_done = 0;
    m0_valid = 1; m1_valid = 1; m0_addr = 32'hA0; m1_addr = 32'hB0;
    s_ready = 1; s_rdata = 32'h0BAD_F00D;
    exp_m1 = !m_last_m1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      checks++;
      if (i % 2 == 0) begin
        if (grant !== (exp_m1 ? 2'b10 : 2'b01) || m0_ready !== !exp_m1 || m1_ready !== exp_m1
            || s_addr !== (exp_m1 ? 32'hB0 : 32'hA0)) begin
          errors++;
          $display("FAIL rr_busy %0d: grant=%b m0_ready=%b m1_ready=%b s_addr=%h, want owner m%0d",
                   i, grant, m0_ready, m1_ready, s_addr, exp_m1);
        end
        m_last_m1 = exp_m1;
        exp_m1 = !exp_m1;
      end else if (grant !== 2'b00) begin
        errors++;
        $display("FAIL rr_idle %0d: grant=%b, want 00", i, grant);
      end
    end
    m0_valid = 0; m1_valid = 0; s_ready = 0;
  endtask

  task automatic test_timeout();
    logic [1:0] g; logic [31:0] sa, rd; int dc; bit gm1, stray;
    run_xfer(1, 0, 32'h4000, 32'h0, 100, 32'h0, g, sa, dc, gm1, rd, stray);
    m_err++; m_last_m1 = 0;
    checks++;
    if (g !== 2'b01 || dc != 8 || gm1 || rd !== ERRD || err_count !== sat_err(m_err)) begin
      errors++;
      $display("FAIL timeout: grant=%b cyc=%0d rdata=%h err=%0d, want 01 8 %h %0d",
               g, dc, rd, err_count, ERRD, sat_err(m_err));
    end
  endtask

  task automatic test_coincidence();
    logic [1:0] g; logic [31:0] sa, rd; int dc; bit gm1, stray;
    run_xfer(1, 0, 32'h4004, 32'h0, 7, 32'h1234_5678, g, sa, dc, gm1, rd, stray);
    m_last_m1 = 0;
    checks++;
    if (dc != 7 || rd !== 32'h1234_5678 || err_count !== sat_err(m_err)) begin
      errors++;
      $display("FAIL coincidence: cyc=%0d rdata=%h err=%0d, want 7 12345678 %0d",
               dc, rd, err_count, sat_err(m_err));
    end
  endtask

  task automatic test_valid_drop();
    m0_valid = 1; m0_addr = 32'h50; s_ready = 0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL drop_grant: grant=%b, want 01", grant);
    end
    m0_valid = 0;
    #1;
    checks++;
    if (m0_ready !== 1'b0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_outputs: m0_ready=%b s_valid=%b, want 0 0", m0_ready, s_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (grant !== 2'b00 || err_count !== sat_err(m_err)) begin
      errors++;
      $display("FAIL drop_idle: grant=%b err=%0d, want 00 %0d", grant, err_count, sat_err(m_err));
    end
  endtask

  task automatic test_random();
    logic [1:0] g; logic [31:0] sa, rd, a0, a1, data; int dc, lat; bit gm1, stray, v0, v1, w_m1;
    int exp_dc; logic [31:0] exp_rd;
    for (int it = 0; it < 40; it++) begin
      v0 = $urandom_range(0, 1); v1 = $urandom_range(0, 1);
      if (!v0 && !v1) v0 = 1;
      a0 = $urandom; a1 = $urandom; data = $urandom;
      lat = $urandom_range(1, 10);
      w_m1 = (v0 && v1) ? !m_last_m1 : v1;
      exp_dc = (lat <= TO - 1) ? lat : TO;
      exp_rd = (lat <= TO - 1) ? data : ERRD;
      run_xfer(v0, v1, a0, a1, lat, data, g, sa, dc, gm1, rd, stray);
      m_last_m1 = w_m1;
      if (lat > TO - 1) m_err++;
      checks++;
      if (g !== (w_m1 ? 2'b10 : 2'b01) || sa !== (w_m1 ? a1 : a0) || gm1 != w_m1 || stray) begin
        errors++;
        $display("FAIL rand_owner %0d: grant=%b s_addr=%h resp_m1=%0d stray=%0d, want m%0d",
                 it, g, sa, gm1, stray, w_m1);
      end
      checks++;
      if (dc != exp_dc || rd !== exp_rd || err_count !== sat_err(m_err)) begin
        errors++;
        $display("FAIL rand_resp %0d: cyc=%0d rdata=%h err=%0d, want %0d %h %0d",
                 it, dc, rd, err_count, exp_dc, exp_rd, sat_err(m_err));
      end
    end
  endtask

  task automatic test_saturation_reset();
    int pulses = 0;
    m0_valid = 1; m1_valid = 0; s_ready = 0; m0_addr = 32'hDEAD;
    for (int c = 0; c < 4000 && pulses < 300; c++) begin
      @(posedge clk); #1;
      if (m0_ready) pulses++;
    end
    m_err += pulses;
    checks++;
    if (pulses != 300) begin
      errors++;
      $display("FAIL sat_pulses: got %0d aborts, want 300", pulses);
    end
    @(posedge clk); #1;
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL saturation: err=%0d, want 255", err_count);
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL mid_busy_grant: grant=%b, want 01", grant);
    end
    #2;
    resetn = 0; s_ready = 1;
    #1;
    checks++;
    if (grant !== 2'b00 || s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: grant=%b s_valid=%b m0_ready=%b m1_ready=%b err=%0d, want all zero",
               grant, s_valid, m0_ready, m1_ready, err_count);
    end
    clear_inputs();
    #1 resetn = 1;
    m_last_m1 = 1; m_err = 0;
    @(posedge clk); #1;
    m1_valid = 1; s_ready = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (m1_ready !== 1'b0 || grant !== 2'b00) begin
        errors++;
        $display("FAIL post_reset_block %0d: m1_ready=%b grant=%b, want 0 00", i, m1_ready, grant);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_boot_gating();
    test_round_robin();
    test_timeout();
    test_coincidence();
    test_valid_drop();
    test_random();
    test_saturation_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_boot_arbiter.md
MEM_BOOT_ARBITER -- requirements
Module: mem_boot_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: cycles a granted transfer may wait for s_ready before the block aborts it; legal range 2..65535.
REQ-002 SHALL have parameter ERR_DATA, default 32'hFFFF_FFFF: read data returned on an aborted transfer.
REQ-003 SHALL have ports clk (input, 1): single clock, all state on the rising edge.
REQ-004 SHALL have port resetn (input, 1): asynchronous, active-low reset.
REQ-005 SHALL have ports m0_valid/m0_ready/m0_addr/m0_wdata/m0_wstrb/m0_rdata (in/out/in/in/in/out; 1/1/32/32/4/32): firmware-loader master.
REQ-006 SHALL have ports m1_valid/m1_ready/m1_addr/m1_wdata/m1_wstrb/m1_rdata (same directions and widths): CPU master.
REQ-007 SHALL have ports s_valid/s_ready/s_addr/s_wdata/s_wstrb/s_rdata (out/in/out/out/out/in; 1/1/32/32/4/32): shared slave bus.
REQ-008 SHALL have port boot_done (input, 1): loader finished; the block latches it.
REQ-009 SHALL have port grant (output, 2): one-hot current owner; bit 0 is m0, bit 1 is m1, 00 when idle.
REQ-010 SHALL have port err_count (output, 8): saturating count of aborted transfers.

Function
REQ-011 SHALL implement the FSM states IDLE, BUSY and ABORT.
REQ-012 SHALL keep a sticky boot_q, set on the first cycle boot_done=1 and cleared only by reset.
REQ-013 While boot_q=0, SHALL treat only m0 as eligible; m1 waits with m1_ready=0 however long it asserts valid.
REQ-014 While boot_q=1, SHALL treat both masters as eligible and arbitrate round-robin: on a simultaneous request, the master not granted last wins.
REQ-015 The last-granted pointer SHALL reset to m1, so the first contested grant after boot goes to m0.
REQ-016 In IDLE with at least one eligible valid, SHALL register the grant and enter BUSY on the next edge; arbitration latency is 1 cycle.
REQ-017 In IDLE, SHALL drive s_valid=0 and both m*_ready=0.
REQ-018 In BUSY, SHALL drive s_valid, s_addr, s_wdata and s_wstrb combinationally from the granted master.
REQ-019 In BUSY, the non-granted master SHALL see ready=0 and rdata=0.
REQ-020 In BUSY with s_ready=1, SHALL assert the granted m*_ready for that same cycle with m*_rdata=s_rdata, update the pointer, and return to IDLE.
REQ-021 Grant SHALL NOT change while in BUSY; there is no preemption.
REQ-022 SHALL keep a 16-bit wait counter: cleared on entry to BUSY, incremented on each BUSY cycle without s_ready.
REQ-023 When the counter reaches TIMEOUT-1 without s_ready, SHALL enter ABORT.
REQ-024 ABORT SHALL last exactly 1 cycle: s_valid=0; granted m*_ready=1 with m*_rdata=ERR_DATA; err_count incremented, saturating at 255; pointer updated; then IDLE.
REQ-025 If the granted master drops valid while in BUSY, SHALL return to IDLE next edge with no ready pulse and no error count.
REQ-026 If s_ready and the timeout coincide in the same cycle, s_ready SHALL win: normal completion, no abort.
REQ-027 A master re-asserting valid in the cycle after its ready SHALL be treated as a new request.
REQ-028 Every output SHALL be a function of registered state and current inputs only; there is no combinational path from s_ready to s_valid.

Reset
REQ-029 On resetn=0, SHALL asynchronously force: state=IDLE, grant=00, s_valid=0, m0_ready=0, m1_ready=0, err_count=0, boot_q=0, pointer=m1, wait counter=0.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer silently; no ready is issued.
REQ-031 SHALL leave reset on the first clk edge after resetn rises.

Verification
REQ-032 Boot gating: boot_done=0, m0 and m1 both valid, slave ready after 2 cycles -> only m0 completes, grant=01, m1_ready stays 0 for 50 cycles.
REQ-033 Round-robin: boot_done=1, both masters continuously valid, s_ready=1 each BUSY cycle -> grants alternate 01,10,01,10; each transfer takes 2 cycles.
REQ-034 Timeout: TIMEOUT=8, m0 read to an address that never gets s_ready -> m0_ready pulses at BUSY cycle 8 with rdata 32'hFFFF_FFFF, err_count=1.
REQ-035 Coincidence: TIMEOUT=8, s_ready on BUSY cycle 7 with s_rdata=32'h1234_5678 -> m0 receives 32'h1234_5678, err_count unchanged.
REQ-036 Saturation and reset: 300 forced timeouts -> err_count=255; resetn pulsed low mid-BUSY -> all outputs zero immediately, boot_q cleared, m1 blocked again.
